// File: rtl/mp_ctrl.sv
// Purpose: micro-program sequencer; fetches 16-bit instructions, drives operand loads, multiplier start and result writes.
// Latency: start-to-OP_READ one cycle; per instruction 6 cycles plus multiplier time; all outputs registered or state decodes.
// Backpressure: OP_CAL holds until mul_done (optional watchdog via MP_TIMEOUT_EN); RESULT holds until host clears the interrupt.
module mp_ctrl #(
    parameter logic [3:0] INST_LAST = 4'hF,
    parameter logic [7:0] TMO_MAX   = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [15:0] s_din,
    input  logic [15:0] m_rdata,
    input  logic        mul_done,
    output logic [3:0]  cur_state,
    output logic [3:0]  w_cnt,
    output logic [15:0] cur_op,
    output logic        s0_sel,
    output logic        ra_ld,
    output logic        rb_ld,
    output logic        mul_start,
    output logic        m_wr,
    output logic        irq,
    output logic        err
);

    typedef enum logic [3:0] {
        INIT     = 4'b0000,
        OP_READ  = 4'b0001,
        OP_WAIT1 = 4'b0010,
        RA_READ  = 4'b0011,
        RB_READ  = 4'b0100,
        OP_WAIT2 = 4'b0101,
        OP_CAL   = 4'b0110,
        SELECT   = 4'b0111,
        RESULT   = 4'b1000
    } state_t;

    state_t state;
    state_t state_nxt;

    logic start_evt;
    logic stop_evt;
    logic cal_first;   // high in the cycle right after OP_WAIT2
    logic res_first;   // high when the previous state was not RESULT
    logic din_unused;

    // Host command decodes; they only steer next-state and register loads.
    assign start_evt  = s_sel & s_wr & (s_addr == 16'h0120) & s_din[0];
    assign stop_evt   = s_sel & s_wr & (s_addr == 16'h0122) & ~s_din[0];
    assign din_unused = ^s_din[15:1];

`ifdef MP_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_hit;

    // The last allowed OP_CAL cycle is the one where the count reads TMO_MAX-1.
    assign tmo_hit = (tmo_cnt == (TMO_MAX - 8'd1));
`else
    logic tmo_unused;
    assign tmo_unused = ^TMO_MAX;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:     if (start_evt) state_nxt = OP_READ;
            OP_READ:  state_nxt = OP_WAIT1;
            OP_WAIT1: state_nxt = (m_rdata[15:12] == 4'h0) ? RESULT : RA_READ;
            RA_READ:  state_nxt = RB_READ;
            RB_READ:  state_nxt = OP_WAIT2;
            OP_WAIT2: state_nxt = OP_CAL;
            OP_CAL: begin
                if (mul_done) state_nxt = SELECT;
`ifdef MP_TIMEOUT_EN
                else if (tmo_hit) state_nxt = RESULT;
`endif
            end
            SELECT:   state_nxt = (w_cnt == INST_LAST) ? RESULT : OP_READ;
            RESULT:   if (stop_evt) state_nxt = INIT;
            default:  state_nxt = INIT;
        endcase
    end

    // State register plus first-cycle markers for OP_CAL and RESULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            cal_first <= 1'b0;
            res_first <= 1'b0;
        end else begin
            state     <= state_nxt;
            cal_first <= (state == OP_WAIT2);
            res_first <= (state != RESULT);
        end
    end

    // Instruction index and latched instruction; both hold across RESULT/INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_cnt  <= 4'd0;
            cur_op <= 16'h0000;
        end else begin
            if (state == INIT && start_evt) begin
                w_cnt <= 4'd0;
            end else if (state == SELECT && w_cnt != INST_LAST) begin
                w_cnt <= w_cnt + 4'd1;
            end
            if (state == OP_WAIT1) begin
                cur_op <= m_rdata;
            end
        end
    end

`ifdef MP_TIMEOUT_EN
    // Watchdog counter over OP_CAL and sticky error flag cleared by the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
            err     <= 1'b0;
        end else begin
            if (state == OP_WAIT2) begin
                tmo_cnt <= 8'd0;
            end else if (state == OP_CAL) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (state == INIT && start_evt) begin
                err <= 1'b0;
            end else if (state == OP_CAL && !mul_done && tmo_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // Output decodes of registered state only.
    assign cur_state = state;
    assign s0_sel    = (state != INIT);
    assign ra_ld     = (state == RB_READ);
    assign rb_ld     = (state == OP_WAIT2);
    assign mul_start = cal_first & (state == OP_CAL);
    assign m_wr      = (state == SELECT) | ((state == RESULT) & res_first);
    assign irq       = (state == RESULT);

endmodule

// File: tb/tb_mp_ctrl.sv
// Purpose: self-checking bench for mp_ctrl against a per-instruction trace model.
// Latency: expectations sampled 1 time unit after each rising clock edge.
// Backpressure: multiplier completion and host writes are scheduled by the model.
module tb_mp_ctrl;

    logic        clk;
    logic        reset;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [15:0] s_din;
    logic [15:0] m_rdata;
    logic        mul_done;
    logic [3:0]  cur_state;
    logic [3:0]  w_cnt;
    logic [15:0] cur_op;
    logic        s0_sel;
    logic        ra_ld;
    logic        rb_ld;
    logic        mul_start;
    logic        m_wr;
    logic        irq;
    logic        err;

    mp_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .m_rdata   (m_rdata),
        .mul_done  (mul_done),
        .cur_state (cur_state),
        .w_cnt     (w_cnt),
        .cur_op    (cur_op),
        .s0_sel    (s0_sel),
        .ra_ld     (ra_ld),
        .rb_ld     (rb_ld),
        .mul_start (mul_start),
        .m_wr      (m_wr),
        .irq       (irq),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory answering the controller's index.
    logic [15:0] prog [16];
    int          kdel [16];   // OP_CAL cycles before mul_done; 0 = never
    assign m_rdata = prog[w_cnt];

    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  wc;
        logic [15:0] op;
        logic        md;
        logic        er;
    } step_t;

    step_t       tr[$];
    logic [3:0]  m_wc;
    logic [15:0] m_op;
    logic        m_err;
    logic [3:0]  m_prev;
    int          n_chk;
    int          n_fail;
    int          sel_wr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [3:0] s, input logic md);
        step_t x;
        x.st = s; x.wc = m_wc; x.op = m_op; x.md = md; x.er = m_err;
        tr.push_back(x);
    endfunction

    // Expand the program into the expected state per clock edge, starting at the start write.
    function automatic void build();
        tr.delete();
        m_wc  = 4'd0;
        m_err = 1'b0;
        push(4'd1, rnd());
        for (int i = 0; i < 16; i++) begin
            push(4'd2, rnd());
            m_op = prog[i];
            if (prog[i][15:12] == 4'h0) begin
                push(4'd8, rnd());
                return;
            end
            push(4'd3, rnd()); push(4'd4, rnd()); push(4'd5, rnd()); push(4'd6, rnd());
            if (kdel[i] == 0) begin
`ifdef MP_TIMEOUT_EN
                for (int c = 1; c < 255; c++) push(4'd6, 1'b0);
                m_err = 1'b1;
                push(4'd8, 1'b0);
`else
                for (int c = 1; c < 300; c++) push(4'd6, 1'b0);
`endif
                return;
            end
            for (int c = 1; c < kdel[i]; c++) push(4'd6, 1'b0);
            push(4'd7, 1'b1);
            if (i == 15) begin
                push(4'd8, rnd());
                return;
            end
            m_wc = m_wc + 4'd1;
            push(4'd1, rnd());
        end
    endfunction

    function automatic logic [6:0] exp_flags(input logic [3:0] s, input logic [3:0] p, input logic e);
        return {s != 4'd0, s == 4'd4, s == 4'd5, (s == 4'd6) && (p != 4'd6),
                (s == 4'd7) || ((s == 4'd8) && (p != 4'd8)), s == 4'd8, e};
    endfunction

    task automatic check_step(input step_t x);
        chk("state", 16'(cur_state), 16'(x.st));
        chk("w_cnt", 16'(w_cnt), 16'(x.wc));
        chk("cur_op", cur_op, x.op);
        chk("flags", 16'({s0_sel, ra_ld, rb_ld, mul_start, m_wr, irq, err}),
            16'(exp_flags(x.st, m_prev, x.er)));
        m_prev = x.st;
    endtask

    task automatic expect_now(input logic [3:0] s);
        step_t x;
        x.st = s; x.wc = m_wc; x.op = m_op; x.md = 1'b0; x.er = m_err;
        check_step(x);
    endtask

    task automatic idle();
        s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'h0000; s_din = 16'h0000; mul_done = 1'b0;
    endtask

    task automatic host_noise();
        s_sel = rnd();
        s_wr  = rnd();
        case ($urandom_range(0, 2))
            0:       s_addr = 16'h0120;
            1:       s_addr = 16'h0122;
            default: s_addr = 16'($urandom);
        endcase
        s_din = 16'($urandom);
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk); #1;
        idle();
    endtask

    // Replay the first n trace steps; every OP_CAL cycle also carries a start write that must be ignored.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            if (j == 0) begin
                s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'h0120; s_din = 16'($urandom) | 16'h0001;
            end else if (tr[j-1].st == 4'd6) begin
                s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'h0120; s_din = 16'h0001;
            end else begin
                host_noise();
            end
            mul_done = tr[j].md;
            @(posedge clk); #1;
            if (m_wr === 1'b1 && cur_state === 4'd7) sel_wr++;
            check_step(tr[j]);
        end
        idle();
    endtask

    task automatic model_reset();
        m_wc = 4'd0; m_op = 16'h0000; m_err = 1'b0; m_prev = 4'd0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            prog[i] = 16'h0000;
            kdel[i] = 1;
        end
    endtask

    task automatic end_prog();
        host_wr(16'h0122, 16'h0000);
        expect_now(4'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; sel_wr = 0;
        idle();
        clear_prog();
        model_reset();
        reset = 1'b1;
        #12;
        expect_now(4'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two-instruction program, multiplier answers in the third OP_CAL cycle; start on first edge.
        prog[0] = 16'h1312; kdel[0] = 3; prog[1] = 16'h0000;
        build();
        sel_wr = 0;
        run(tr.size());
        chk("one_select_write", 16'(sel_wr), 16'd1);

        // Interrupt acknowledge with bit0=1 is ignored, with bit0=0 returns to INIT.
        host_wr(16'h0122, 16'h0001);
        expect_now(4'd8);
        host_wr(16'h0120, 16'h0000);
        expect_now(4'd8);
        end_prog();
        mul_done = 1'b1;
        host_wr(16'h0122, 16'h0000);
        expect_now(4'd0);

        // Full sixteen-slot program, fastest multiplier.
        for (int i = 0; i < 16; i++) begin
            prog[i] = 16'h1000 | 16'(i * 16'h0111);
            kdel[i] = 1;
        end
        build();
        sel_wr = 0;
        run(tr.size());
        chk("sixteen_select_writes", 16'(sel_wr), 16'd16);
        end_prog();

        // Random programs with random HALT placement and multiplier latency.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++) begin
                prog[i] = 16'($urandom);
                if ($urandom_range(0, 7) == 0) prog[i][15:12] = 4'h0;
                else if (prog[i][15:12] == 4'h0) prog[i][15:12] = 4'h5;
                kdel[i] = $urandom_range(1, 4);
            end
            build();
            run(tr.size());
            end_prog();
        end

        // Asynchronous reset in the middle of OP_CAL; later mul_done must not wake it.
        clear_prog();
        prog[0] = 16'h2abc; kdel[0] = 4; prog[1] = 16'h0000;
        build();
        begin
            int idx;
            idx = 0;
            while (idx < tr.size() && tr[idx].st != 4'd6) idx++;
            run(idx + 1);
        end
        #2 reset = 1'b1;
        #1 model_reset();
        expect_now(4'd0);
        @(negedge clk);
        reset = 1'b0;
        mul_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            expect_now(4'd0);
        end
        idle();

        // Multiplier never answers.
        prog[0] = 16'h3456; kdel[0] = 0;
        build();
        run(tr.size());
`ifdef MP_TIMEOUT_EN
        end_prog();
`else
        #2 reset = 1'b1;
        #1 model_reset();
        expect_now(4'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        // A fresh start clears any error and a leading HALT goes straight to RESULT.
        clear_prog();
        build();
        run(tr.size());
        end_prog();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mp_ctrl.md
MP_CTRL -- requirements
Module: mp_ctrl

Interface
REQ-001 SHALL have parameters: INST_LAST, default 4'hF, index of last instruction slot; TMO_MAX, default 8'd255, OP_CAL watchdog limit in cycles.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; single clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 s_sel  in  1  host slave select; s_wr  in  1  host write strobe.
REQ-005 s_addr  in  16  host address; s_din  in  16  host write data.
REQ-006 m_rdata  in  16  bus read data, valid one cycle after address is presented.
REQ-007 mul_done  in  1  multiplier result valid pulse.
REQ-008 cur_state  out  4  state code, consumed by the address mux.
REQ-009 w_cnt  out  4  instruction index; cur_op  out  16  latched instruction: [15:12] opcode, [11:8] Rd, [7:4] Ra, [3:0] Rb.
REQ-010 s0_sel  out  1  controller owns bus (address high byte 8'h01).
REQ-011 ra_ld, rb_ld, mul_start, m_wr, irq, err  out  1 each.

Function
REQ-012 State codes SHALL be INIT 0000, OP_READ 0001, OP_WAIT1 0010, RA_READ 0011, RB_READ 0100, OP_WAIT2 0101, OP_CAL 0110, SELECT 0111, RESULT 1000; cur_state SHALL be the registered state.
REQ-013 Start event = s_sel & s_wr & s_addr==16'h0120 & s_din[0]; in INIT it SHALL clear w_cnt to 0 and go to OP_READ next cycle; outside INIT it SHALL be ignored.
REQ-014 OP_READ -> OP_WAIT1 unconditionally.
REQ-015 OP_WAIT1 SHALL load cur_op <= m_rdata; opcode 4'h0 (HALT) -> RESULT, else -> RA_READ.
REQ-016 RA_READ -> RB_READ; ra_ld SHALL be 1 during RB_READ only.
REQ-017 RB_READ -> OP_WAIT2; rb_ld SHALL be 1 during OP_WAIT2 only.
REQ-018 OP_WAIT2 -> OP_CAL; mul_start SHALL be 1 for exactly the first OP_CAL cycle.
REQ-019 OP_CAL SHALL hold until mul_done=1, then -> SELECT; a mul_done outside OP_CAL SHALL be ignored.
REQ-020 SELECT SHALL assert m_wr for one cycle; if w_cnt==INST_LAST -> RESULT, else w_cnt <= w_cnt+1 (4-bit, no wrap needed) and -> OP_READ.
REQ-021 RESULT SHALL assert m_wr in its first cycle only (interrupt-register write) and irq continuously while in RESULT.
REQ-022 RESULT -> INIT on s_sel & s_wr & s_addr==16'h0122 & s_din[0]==0; other host writes SHALL be ignored.
REQ-023 s0_sel SHALL be 0 in INIT and 1 in every other state.
REQ-024 cur_op and w_cnt SHALL hold their values from the last instruction through RESULT and INIT until the next start.
REQ-025 All outputs SHALL be registered or pure decodes of registered state; no combinational path from s_* to outputs.

Reset
REQ-026 reset=1 SHALL force INIT immediately regardless of clk, from any state including OP_CAL.
REQ-027 Reset values: cur_state 0000, w_cnt 0, cur_op 16'h0000, s0_sel 0, ra_ld 0, rb_ld 0, mul_start 0, m_wr 0, irq 0, err 0.
REQ-028 First start after reset deassertion SHALL be accepted on the first clk edge.

Configuration
REQ-029 Macro MP_TIMEOUT_EN defined: an 8-bit counter SHALL clear on OP_CAL entry and increment each OP_CAL cycle; reaching TMO_MAX without mul_done SHALL set err=1 and go to RESULT (no SELECT write); err SHALL clear only on start or reset.
REQ-030 MP_TIMEOUT_EN undefined: no counter; OP_CAL waits indefinitely; err SHALL be tied 0.

Verification
REQ-031 Start with inst0=16'h1312, mul_done 3 cycles after mul_start, inst1=16'h0000 -> state sequence 1,2,3,4,5,6,6,6,7,1,2,8; ra_ld in RB_READ, rb_ld in OP_WAIT2, one m_wr in SELECT, w_cnt 0->1, irq=1.
REQ-032 All 16 slots non-HALT, mul_done after 1 cycle each -> 16 SELECT writes, w_cnt ends 4'hF, RESULT entered from SELECT.
REQ-033 In RESULT write 16'h0001 to 16'h0122 -> stays RESULT; write 16'h0000 -> INIT next cycle, irq=0, s0_sel=0.
REQ-034 reset pulse during OP_CAL between clk edges -> cur_state=0000 and all outputs 0 before next edge; later mul_done ignored.
REQ-035 MP_TIMEOUT_EN, mul_done never asserted -> err=1 and RESULT after 255 OP_CAL cycles, no SELECT m_wr; without macro -> remains in OP_CAL.
REQ-036 Start write while in OP_CAL -> no change to state, w_cnt or cur_op.
